// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared definitions for the ping-pong image buffer controller:
// bank-state encoding, bank count and a one-hot helper.
package pingpong_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic sel);
        logic [NUM_BANKS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// Loader/reader-facing signal bundle of the ping-pong buffer controller.
// master = loader/reader side, slave = controller side.
interface pingpong_buf_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    import pingpong_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_BANKS-1:0]  buf_wr_en;
    logic [ADDR_WIDTH-1:0] buf_wr_addr;
    logic                  frame_valid;
    logic                  rd_sel;
    logic                  frame_done;
    logic [NUM_BANKS-1:0]  bank_full;
    logic                  err;

    modport master (
        output in_valid, frame_done,
        input  in_ready, buf_wr_en, buf_wr_addr, frame_valid, rd_sel, bank_full, err
    );

    modport slave (
        input  in_valid, frame_done,
        output in_ready, buf_wr_en, buf_wr_addr, frame_valid, rd_sel, bank_full, err
    );

endinterface

// File: rtl/pingpong_bank_state.sv
// Single-bank lifecycle register: EMPTY -> FILLING -> FULL -> EMPTY.
// Async active-high reset returns the bank to EMPTY.
module pingpong_bank_state
    import pingpong_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_filling,
    input  logic        set_full,
    input  logic        release_bank,
    output bank_state_t state
);

    bank_state_t state_q;
    bank_state_t state_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BANK_EMPTY;
        else     state_q <= state_nxt;
    end

    // NOTE: hold-value default first, so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            BANK_EMPTY:   if (set_filling)  state_nxt = BANK_FILLING;
            BANK_FILLING: if (set_full)     state_nxt = BANK_FULL;
            BANK_FULL:    if (release_bank) state_nxt = BANK_EMPTY;
            default:                        state_nxt = BANK_EMPTY;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank ping-pong image buffer sequencer; asynchronous active-high reset (rst).
// Optional sticky protocol checker enabled by defining PPBUF_ERR_EN.
module pingpong_buf_ctrl
    import pingpong_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    pingpong_buf_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH);

    bank_state_t           bank_state [NUM_BANKS];
    logic [NUM_BANKS-1:0]  set_filling;
    logic [NUM_BANKS-1:0]  set_full;
    logic [NUM_BANKS-1:0]  release_bank;

    logic                  wr_sel, wr_sel_nxt;
    logic                  rd_sel, rd_sel_nxt;
    logic [CNT_W-1:0]      wr_cnt, wr_cnt_nxt;
    logic                  full_pend, full_pend_nxt;
    logic                  full_bank, full_bank_nxt;
    logic [NUM_BANKS-1:0]  wr_en_q, wr_en_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;

    logic                  in_ready;
    logic                  frame_valid;
    logic                  accept;
    logic [NUM_BANKS-1:0]  bank_full;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pingpong_bank_state u_bank (
            .clk          (clk),
            .rst          (rst),
            .set_filling  (set_filling[b]),
            .set_full     (set_full[b]),
            .release_bank (release_bank[b]),
            .state        (bank_state[b])
        );
    end

    assign in_ready    = (bank_state[wr_sel] != BANK_FULL);
    assign frame_valid = (bank_state[rd_sel] == BANK_FULL);
    assign accept      = bus.in_valid & in_ready;

    always_comb begin
        wr_sel_nxt    = wr_sel;
        rd_sel_nxt    = rd_sel;
        wr_cnt_nxt    = wr_cnt;
        full_pend_nxt = 1'b0;
        full_bank_nxt = full_bank;
        wr_en_nxt     = '0;
        wr_addr_nxt   = wr_addr_q;
        set_filling   = '0;
        set_full      = '0;
        release_bank  = '0;

        // The bank turns FULL one edge after its last word so the write lands first.
        if (full_pend) set_full[full_bank] = 1'b1;

        if (accept) begin
            wr_en_nxt   = bank_onehot(wr_sel);
            wr_addr_nxt = ADDR_WIDTH'(wr_cnt);
            if (bank_state[wr_sel] == BANK_EMPTY) set_filling[wr_sel] = 1'b1;
            if (wr_cnt == CNT_W'(DEPTH - 1)) begin
                wr_cnt_nxt    = '0;
                wr_sel_nxt    = ~wr_sel;
                full_pend_nxt = 1'b1;
                full_bank_nxt = wr_sel;
            end else begin
                wr_cnt_nxt = wr_cnt + CNT_W'(1);
            end
        end

        if (bus.frame_done && frame_valid) begin
            release_bank[rd_sel] = 1'b1;
            rd_sel_nxt           = ~rd_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
            full_pend <= 1'b0;
            full_bank <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
        end else begin
            wr_sel    <= wr_sel_nxt;
            rd_sel    <= rd_sel_nxt;
            wr_cnt    <= wr_cnt_nxt;
            full_pend <= full_pend_nxt;
            full_bank <= full_bank_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
        end
    end

    always_comb begin
        bank_full = '0;
        for (int b = 0; b < NUM_BANKS; b++) bank_full[b] = (bank_state[b] == BANK_FULL);
    end

    assign bus.in_ready    = in_ready;
    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.frame_valid = frame_valid;
    assign bus.rd_sel      = rd_sel;
    assign bus.bank_full   = bank_full;

`ifdef PPBUF_ERR_EN
    logic err_q;
    logic wr_hits_full;

    // A strobe is in flight for one cycle; it must never meet a bank already FULL.
    always_comb begin
        wr_hits_full = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (wr_en_q[b] && bank_state[b] == BANK_FULL) wr_hits_full = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 err_q <= 1'b0;
        else if ((bus.frame_done && !frame_valid) || wr_hits_full) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Self-checking bench for pingpong_buf_ctrl: directed scenarios plus randomized
// loader/reader traffic against a word-count based reference model.
module tb_pingpong_buf_ctrl;

    localparam int DEPTH      = 32;
    localparam int ADDR_WIDTH = 16;

    logic clk;
    logic rst;

    pingpong_buf_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    pingpong_buf_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: words accepted per bank, edge at which a complete bank becomes visible.
    int   words     [2];
    int   full_edge [2];
    int   wr, rd, e;
    logic [1:0]  exp_en;
    logic [31:0] exp_addr;
    logic        err_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit vis_full(input int b);
        return (words[b] == DEPTH) && (e >= full_edge[b]);
    endfunction

    task automatic model_reset();
        words[0] = 0; words[1] = 0;
        full_edge[0] = 0; full_edge[1] = 0;
        wr = 0; rd = 0; e = 0;
        exp_en = 2'b00; exp_addr = 0; err_m = 1'b0;
    endtask

    task automatic model_edge();
        bit acc, done, ready_pre, fv_pre;
        ready_pre = (words[wr] < DEPTH);
        fv_pre    = vis_full(rd);
        acc  = bus.in_valid && ready_pre;
        done = bus.frame_done && fv_pre;
`ifdef PPBUF_ERR_EN
        if (bus.frame_done && !fv_pre) err_m = 1'b1;
`endif
        e++;
        exp_en = 2'b00;
        if (acc) begin
            exp_en   = (wr == 0) ? 2'b01 : 2'b10;
            exp_addr = words[wr];
            words[wr]++;
            if (words[wr] == DEPTH) begin
                full_edge[wr] = e + 1;
                wr ^= 1;
            end
        end
        if (done) begin
            words[rd] = 0;
            rd ^= 1;
        end
    endtask

    task automatic compare_all();
        check("in_ready",    32'(bus.in_ready),    32'(words[wr] < DEPTH));
        check("frame_valid", 32'(bus.frame_valid), 32'(vis_full(rd)));
        check("rd_sel",      32'(bus.rd_sel),      32'(rd));
        check("bank_full",   32'(bus.bank_full),   {30'd0, vis_full(1), vis_full(0)});
        check("buf_wr_en",   32'(bus.buf_wr_en),   32'(exp_en));
        if (exp_en != 2'b00) check("buf_wr_addr", 32'(bus.buf_wr_addr), exp_addr);
        check("err",         32'(bus.err),         32'(err_m));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asserts rst mid-cycle to exercise the asynchronous path, checks reset values.
    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.frame_done = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready",    32'(bus.in_ready),    32'd1);
        check("rst_buf_wr_en",   32'(bus.buf_wr_en),   32'd0);
        check("rst_buf_wr_addr", 32'(bus.buf_wr_addr), 32'd0);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_rd_sel",      32'(bus.rd_sel),      32'd0);
        check("rst_bank_full",   32'(bus.bank_full),   32'd0);
        check("rst_err",         32'(bus.err),         32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    int frames_seen;
    int delay;
    int cycles;

    initial begin
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.frame_done = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fill bank 0 with back-to-back words.
        bus.in_valid = 1'b1;
        repeat (DEPTH) step();
        check("fill0_last_en",   32'(bus.buf_wr_en),   32'h1);
        check("fill0_last_addr", 32'(bus.buf_wr_addr), DEPTH - 1);
        check("fill0_fv_early",  32'(bus.frame_valid), 32'd0);
        step();
        check("fill0_fv",        32'(bus.frame_valid), 32'd1);
        check("fill0_rd_sel",    32'(bus.rd_sel),      32'd0);
        check("fill1_first_en",  32'(bus.buf_wr_en),   32'h2);

        // Fill bank 1 without releasing bank 0; writer must stall.
        repeat (DEPTH - 1) step();
        repeat (2) step();
        check("both_full",       32'(bus.bank_full),   32'h3);
        check("both_in_ready",   32'(bus.in_ready),    32'd0);
        check("both_no_strobe",  32'(bus.buf_wr_en),   32'd0);

        // Release bank 0 while writer is stalled on it.
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        check("rel0_rd_sel",     32'(bus.rd_sel),      32'd1);
        check("rel0_fv",         32'(bus.frame_valid), 32'd1);
        check("rel0_bank_full",  32'(bus.bank_full),   32'h2);
        check("rel0_in_ready",   32'(bus.in_ready),    32'd1);
        step();
        check("refill_en",       32'(bus.buf_wr_en),   32'h1);
        check("refill_addr",     32'(bus.buf_wr_addr), 32'd0);

        // Release bank 1, then a spurious frame_done with nothing presented.
        bus.in_valid   = 1'b0;
        bus.frame_done = 1'b1;
        step();
        step();
        bus.frame_done = 1'b0;
        check("spur_rd_sel",     32'(bus.rd_sel),      32'd0);
        check("spur_bank_full",  32'(bus.bank_full),   32'd0);
        check("spur_fv",         32'(bus.frame_valid), 32'd0);
`ifdef PPBUF_ERR_EN
        check("spur_err",        32'(bus.err),         32'd1);
`else
        check("spur_err",        32'(bus.err),         32'd0);
`endif

        // Reset in the middle of a frame discards the partial frame.
        do_reset();
        bus.in_valid = 1'b1;
        repeat (10) step();
        do_reset();
        bus.in_valid = 1'b1;
        step();
        check("restart_en",      32'(bus.buf_wr_en),   32'h1);
        check("restart_addr",    32'(bus.buf_wr_addr), 32'd0);

        // Random loader gaps and reader release delays over eight frames.
        frames_seen = 0;
        delay       = $urandom_range(0, 20);
        cycles      = 0;
        while (frames_seen < 8 && cycles < 4000) begin
            bus.in_valid   = ($urandom_range(0, 1) == 1);
            bus.frame_done = 1'b0;
            if (vis_full(rd)) begin
                if (delay == 0) begin
                    check("frame_bank", 32'(bus.rd_sel), 32'(frames_seen % 2));
                    bus.frame_done = 1'b1;
                    frames_seen++;
                    delay = $urandom_range(0, 20);
                end else begin
                    delay--;
                end
            end
            step();
            cycles++;
        end
        bus.in_valid   = 1'b0;
        bus.frame_done = 1'b0;
        check("frames_released", 32'(frames_seen), 32'd8);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpong_buf_ctrl.md
# pingpong_buf_ctrl

Controller that sequences the two-bank ping-pong image buffer in front of the convolution engine. It accepts a stream of image words from the loader, generates the write strobe and address for whichever bank is currently filling, and presents each completely filled bank to the convolution reader until the reader releases it. Loading of frame N+1 overlaps convolution of frame N; the controller enforces that a bank is never written while it is being read.

## Interface
Parameters:
- DEPTH, 32, words per bank (one frame); must be ≥ 2
- ADDR_WIDTH, 16, width of buffer write address; DEPTH ≤ 2^ADDR_WIDTH

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  loader offers a word
- in_ready  out  1  controller accepts the word this cycle
- buf_wr_en  out  2  one-hot write strobe, bit b → bank b
- buf_wr_addr  out  ADDR_WIDTH  write address within the selected bank
- frame_valid  out  1  bank rd_sel holds a complete frame
- rd_sel  out  1  bank the reader must read; drives read-side mux
- frame_done  in  1  single-cycle pulse: reader finished bank rd_sel
- bank_full  out  2  bit b set while bank b is FULL
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Per-bank state: EMPTY → FILLING → FULL → EMPTY.
- Write pointer wr_sel, word counter wr_cnt (0..DEPTH-1), read pointer rd_sel.
- in_ready = bank[wr_sel] is EMPTY or FILLING. Purely a function of registered state.
- Accept (in_valid & in_ready): bank[wr_sel] EMPTY→FILLING on first word; wr_cnt increments; on wr_cnt == DEPTH-1, wr_cnt → 0, wr_sel toggles, bank marked for FULL.
- frame_valid = bank[rd_sel] is FULL. rd_sel toggles only on frame_done while frame_valid; bank[rd_sel] → EMPTY at the same edge.
- frame_done while frame_valid low: ignored (flags err when enabled).
- Simultaneous frame_done releasing bank b and writer stalled on bank b: bank b EMPTY after the edge, in_ready high the next cycle.
- Both banks FULL: in_ready low until a frame_done.
- Reset (any time, including mid-frame): banks EMPTY, wr_sel=rd_sel=0, wr_cnt=0; partial frame discarded.

## Timing
- Reset values: in_ready=1, buf_wr_en=0, buf_wr_addr=0, frame_valid=0, rd_sel=0, bank_full=0, err=0.
- buf_wr_en/buf_wr_addr registered: handshake at edge t → strobe and address valid in cycle t+1 (one-cycle latency); buffer write data is delayed one stage externally by the loader path.
- Last word accepted at edge t → write lands at edge t+1 → bank FULL and frame_valid high from cycle t+2 (data guaranteed written before reader sees it).
- Throughput: one word per cycle; back-to-back frames need no idle cycle if next bank EMPTY.
- frame_done at edge t → frame_valid/rd_sel reflect the other bank from cycle t+1; frame_valid stays high with rd_sel changed if the other bank is already FULL.
- Address width: wr_cnt zero-extended into buf_wr_addr.

## Configuration
- PPBUF_ERR_EN defined: err sets (sticky until rst) on frame_done while frame_valid is low, or when a write strobe would target a bank in FULL state (internal assertion path).
- Not defined: err tied 0, checking logic absent; port remains for interface stability.

## Structure
- Shared package pingpong_pkg: bank-state encoding (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2), NUM_BANKS=2.
- One natural sub-module: pingpong_bank_state — single-bank state register with set_filling/set_full/release inputs, instantiated twice.

## Test plan
- Reset, in_valid held high for 32 cycles → buf_wr_addr 0..31 on bank 0 (buf_wr_en=2'b01), frame_valid high 2 cycles after last handshake, rd_sel=0.
- Continue streaming 32 more words without frame_done → bank 1 fills (buf_wr_en=2'b10), bank_full=2'b11, in_ready low; further in_valid produces no strobes.
- With both full, pulse frame_done → rd_sel=1, frame_valid stays high, bank_full=2'b10, in_ready high next cycle, next write at bank 0 addr 0.
- frame_done pulsed with frame_valid low → no state change; err=1 with PPBUF_ERR_EN, err=0 without.
- Assert rst after 10 words of a frame → all outputs at reset values; next frame restarts bank 0 addr 0.
- Random in_valid gaps (≈50%) over 8 frames with reader done after random delays → every frame's 32 words written in order, no write to a FULL bank, frames presented alternating banks.
